// File: rtl/ddr4_v2_2_24_tg_rd_checker.sv
// ddr4_v2_2_24_tg_rd_checker
// Passive read-data checker for the 2:1 traffic-generator path. It snoops the
// TG command handshake and queues the address of every accepted read. Each
// returning full-width read beat is compared lane by lane against an
// address-derived pattern: 32-bit lane i must equal addr[31:0] + i.
// It reports sticky error status, saturating counters and a first-failure
// capture. The block never drives the TG/converter handshake.
//
// Pipeline:
//   edge 0 : beat sampled, FIFO head popped, lane mismatch vector registered
//   edge 1 : error status, counters and capture committed
// Status is therefore visible two cycles after the beat.
module ddr4_v2_2_24_tg_rd_checker #(
   parameter int TCQ                = 100,
   parameter int APP_DATA_WIDTH_2_1 = 512,
   parameter int APP_ADDR_WIDTH     = 32,
   parameter int APP_CMD_WIDTH      = 3,
   parameter int EXP_DEPTH          = 16,
   parameter int LOG2EXP_DEPTH      = 4,
   parameter int CNT_WIDTH          = 32
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               chk_en,
   input  logic                               clr_err,
   input  logic                               tg_en,
   input  logic                               tg_rdy,
   input  logic [APP_CMD_WIDTH-1:0]           tg_cmd,
   input  logic [APP_ADDR_WIDTH-1:0]          tg_addr,
   input  logic                               tg_rd_data_valid,
   input  logic [APP_DATA_WIDTH_2_1-1:0]      tg_rd_data,
   output logic                               chk_busy,
   output logic [LOG2EXP_DEPTH:0]             outstanding,
   output logic                               err_flag,
   output logic [CNT_WIDTH-1:0]               err_cnt,
   output logic [CNT_WIDTH-1:0]               cmp_cnt,
   output logic                               first_err_vld,
   output logic [APP_ADDR_WIDTH-1:0]          first_err_addr,
   output logic [APP_DATA_WIDTH_2_1/32-1:0]   first_err_lanes,
   output logic                               fifo_ovf,
   output logic                               unexp_data
);

   localparam int LANES = APP_DATA_WIDTH_2_1 / 32;

   localparam logic [APP_CMD_WIDTH-1:0]   CMD_RD    = APP_CMD_WIDTH'(1);
   localparam logic [LOG2EXP_DEPTH:0]     DEPTH_CNT = (LOG2EXP_DEPTH+1)'(EXP_DEPTH);
   localparam logic [LOG2EXP_DEPTH:0]     OCC_ONE   = (LOG2EXP_DEPTH+1)'(1);
   localparam logic [LOG2EXP_DEPTH-1:0]   PTR_ONE   = LOG2EXP_DEPTH'(1);
   localparam logic [CNT_WIDTH-1:0]       CNT_ONE   = CNT_WIDTH'(1);

   // Reject parameter sets the datapath cannot represent (lane slicing,
   // power-of-two pointer wrap, non-negative clock-to-Q).
   if ((APP_DATA_WIDTH_2_1 % 32) != 0 || APP_DATA_WIDTH_2_1 < 32 ||
       (1 << LOG2EXP_DEPTH) != EXP_DEPTH || TCQ < 0 || CNT_WIDTH < 1) begin : g_param_check
      $error("ddr4_v2_2_24_tg_rd_checker: illegal parameter combination");
   end

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   state_t state, state_nxt;

   // Expected-address FIFO (show-ahead)
   logic [APP_ADDR_WIDTH-1:0] fifo_mem [EXP_DEPTH];
   logic [LOG2EXP_DEPTH-1:0]  wr_ptr;
   logic [LOG2EXP_DEPTH-1:0]  rd_ptr;
   logic [LOG2EXP_DEPTH:0]    fifo_cnt;
   logic                      fifo_empty;
   logic                      fifo_full;

   // Handshake decode
   logic rd_cmd;
   logic beat_chk;
   logic pop;
   logic push_acc;
   logic ovf_evt;

   // Compare datapath
   logic [31:0]       head_addr32;
   logic [LANES-1:0]  lane_mis;

   // Stage 1: registered compare result
   logic                      s1_vld;
   logic                      s1_unexp;
   logic [APP_ADDR_WIDTH-1:0] s1_addr;
   logic [LANES-1:0]          s1_lanes;
   logic                      s1_fail;

   assign fifo_empty = (fifo_cnt == '0);
   assign fifo_full  = (fifo_cnt == DEPTH_CNT);

   // A read is tracked only while actively running; DRAIN accepts no pushes.
   assign rd_cmd   = tg_en & tg_rdy & (tg_cmd == CMD_RD) & (state == ST_RUN);
   // Beats are ignored while IDLE, checked in RUN and DRAIN.
   assign beat_chk = tg_rd_data_valid & (state != ST_IDLE);
   assign pop      = beat_chk & ~fifo_empty;
   // A full FIFO still accepts a push when the head leaves on the same cycle.
   assign push_acc = rd_cmd & (~fifo_full | pop);
   assign ovf_evt  = rd_cmd & fifo_full & ~pop;

   assign chk_busy    = (state != ST_IDLE);
   assign outstanding = fifo_cnt;

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of block ordering.
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   // FSM next-state decode
   always_comb begin
      // NOTE: defaulting every combinational output first keeps unassigned
      // paths from inferring latches.
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (chk_en) state_nxt = ST_RUN;
         end
         ST_RUN: begin
            if (!chk_en) state_nxt = fifo_empty ? ST_IDLE : ST_DRAIN;
         end
         ST_DRAIN: begin
            if (chk_en)          state_nxt = ST_RUN;
            else if (fifo_empty) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // FIFO storage write
   always_ff @(posedge clk) begin
      // NOTE: the storage array is deliberately not reset; the pointers and
      // occupancy define what is valid, so reset only needs to clear those.
      if (push_acc) fifo_mem[wr_ptr] <= tg_addr;
   end

   // FIFO pointers and occupancy
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         fifo_cnt <= '0;
      end else begin
         if (push_acc) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)      rd_ptr <= rd_ptr + PTR_ONE;
         if (push_acc && !pop)      fifo_cnt <= fifo_cnt + OCC_ONE;
         else if (pop && !push_acc) fifo_cnt <= fifo_cnt - OCC_ONE;
      end
   end

   // Expected pattern from the FIFO head and per-lane mismatch vector
   always_comb begin
      head_addr32 = 32'(fifo_mem[rd_ptr]);
      lane_mis    = '0;
      for (int i = 0; i < LANES; i++) begin
         lane_mis[i] = (tg_rd_data[i*32 +: 32] != (head_addr32 + 32'(i)));
      end
   end

   // Stage 1: capture the compare result of the sampled beat
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_vld   <= 1'b0;
         s1_unexp <= 1'b0;
         s1_addr  <= '0;
         s1_lanes <= '0;
      end else begin
         s1_vld   <= beat_chk;
         s1_unexp <= beat_chk & fifo_empty;
         // An unexpected beat has no address to blame and fails every lane.
         s1_addr  <= fifo_empty ? '0 : fifo_mem[rd_ptr];
         s1_lanes <= fifo_empty ? '1 : lane_mis;
      end
   end

   // Unexpected beats carry an all-ones mask, so one reduction covers both.
   assign s1_fail = s1_vld & (|s1_lanes);

   // Stage 2: saturating counters; a commit on the clear cycle still counts
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_cnt <= '0;
         cmp_cnt <= '0;
      end else begin
         if (clr_err)                      cmp_cnt <= s1_vld ? CNT_ONE : '0;
         else if (s1_vld && cmp_cnt != '1) cmp_cnt <= cmp_cnt + CNT_ONE;

         if (clr_err)                       err_cnt <= s1_fail ? CNT_ONE : '0;
         else if (s1_fail && err_cnt != '1) err_cnt <= err_cnt + CNT_ONE;
      end
   end

   // Stage 2: sticky status flags; a new event wins over a coincident clear
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_flag   <= 1'b0;
         unexp_data <= 1'b0;
         fifo_ovf   <= 1'b0;
      end else begin
         if (s1_fail)      err_flag <= 1'b1;
         else if (clr_err) err_flag <= 1'b0;

         if (s1_vld && s1_unexp) unexp_data <= 1'b1;
         else if (clr_err)       unexp_data <= 1'b0;

         if (ovf_evt)      fifo_ovf <= 1'b1;
         else if (clr_err) fifo_ovf <= 1'b0;
      end
   end

   // Stage 2: first-failure capture, reopened by a clear on the same cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         first_err_vld   <= 1'b0;
         first_err_addr  <= '0;
         first_err_lanes <= '0;
      end else begin
         if (s1_fail && (!first_err_vld || clr_err)) begin
            first_err_vld   <= 1'b1;
            first_err_addr  <= s1_addr;
            first_err_lanes <= s1_lanes;
         end else if (clr_err) begin
            first_err_vld   <= 1'b0;
            first_err_addr  <= '0;
            first_err_lanes <= '0;
         end
      end
   end

endmodule

// File: tb/tb_ddr4_v2_2_24_tg_rd_checker.sv
// tb_ddr4_v2_2_24_tg_rd_checker
// Directed scenarios followed by randomized traffic. A queue-based reference
// model predicts every output each cycle; literal checks pin key scenarios.
`timescale 1ns/1ps
module tb_ddr4_v2_2_24_tg_rd_checker;

   localparam int DW    = 512;
   localparam int AW    = 32;
   localparam int CW    = 3;
   localparam int DEPTH = 16;
   localparam int LOG2D = 4;
   localparam int CNTW  = 32;
   localparam int LANES = DW / 32;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            chk_en = 1'b0;
   logic            clr_err = 1'b0;
   logic            tg_en = 1'b0;
   logic            tg_rdy = 1'b0;
   logic [CW-1:0]   tg_cmd = '0;
   logic [AW-1:0]   tg_addr = '0;
   logic            tg_rd_data_valid = 1'b0;
   logic [DW-1:0]   tg_rd_data = '0;

   logic               chk_busy;
   logic [LOG2D:0]     outstanding;
   logic               err_flag;
   logic [CNTW-1:0]    err_cnt;
   logic [CNTW-1:0]    cmp_cnt;
   logic               first_err_vld;
   logic [AW-1:0]      first_err_addr;
   logic [LANES-1:0]   first_err_lanes;
   logic               fifo_ovf;
   logic               unexp_data;

   int n_chk  = 0;
   int n_fail = 0;

   ddr4_v2_2_24_tg_rd_checker #(
      .TCQ(100), .APP_DATA_WIDTH_2_1(DW), .APP_ADDR_WIDTH(AW), .APP_CMD_WIDTH(CW),
      .EXP_DEPTH(DEPTH), .LOG2EXP_DEPTH(LOG2D), .CNT_WIDTH(CNTW)
   ) dut (
      .clk(clk), .rst_n(rst_n), .chk_en(chk_en), .clr_err(clr_err),
      .tg_en(tg_en), .tg_rdy(tg_rdy), .tg_cmd(tg_cmd), .tg_addr(tg_addr),
      .tg_rd_data_valid(tg_rd_data_valid), .tg_rd_data(tg_rd_data),
      .chk_busy(chk_busy), .outstanding(outstanding), .err_flag(err_flag),
      .err_cnt(err_cnt), .cmp_cnt(cmp_cnt), .first_err_vld(first_err_vld),
      .first_err_addr(first_err_addr), .first_err_lanes(first_err_lanes),
      .fifo_ovf(fifo_ovf), .unexp_data(unexp_data)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef enum int {M_IDLE, M_RUN, M_DRAIN} mst_t;

   logic [31:0]      m_q[$];
   mst_t             m_st = M_IDLE;
   bit               m_err_flag, m_fev, m_ovf, m_unexp;
   logic [CNTW-1:0]  m_err_cnt = '0, m_cmp_cnt = '0;
   logic [AW-1:0]    m_faddr = '0;
   logic [LANES-1:0] m_flanes = '0;
   // Result of the beat seen on the previous edge, committed on the next one.
   bit               p_vld, p_unexp;
   logic [AW-1:0]    p_addr = '0;
   logic [LANES-1:0] p_lanes = '0;

   task automatic model_reset();
      m_q.delete();
      m_st = M_IDLE;
      m_err_flag = 0; m_fev = 0; m_ovf = 0; m_unexp = 0;
      m_err_cnt = '0; m_cmp_cnt = '0; m_faddr = '0; m_flanes = '0;
      p_vld = 0; p_unexp = 0; p_addr = '0; p_lanes = '0;
   endtask

   task automatic model_step();
      int   sz = m_q.size();
      mst_t st = m_st;
      bit   beat = tg_rd_data_valid && (st != M_IDLE);
      bit   rdc  = tg_en && tg_rdy && (tg_cmd == 3'b001) && (st == M_RUN);
      bit   popped = beat && (sz > 0);
      bit   fail;
      // commit of the beat seen one edge earlier (clear first, event wins)
      if (clr_err) begin
         m_err_flag = 0; m_fev = 0; m_ovf = 0; m_unexp = 0;
         m_err_cnt = '0; m_cmp_cnt = '0; m_faddr = '0; m_flanes = '0;
      end
      if (p_vld) begin
         fail = p_unexp || (p_lanes != '0);
         if (m_cmp_cnt != '1) m_cmp_cnt = m_cmp_cnt + 1;
         if (p_unexp) m_unexp = 1;
         if (fail) begin
            m_err_flag = 1;
            if (m_err_cnt != '1) m_err_cnt = m_err_cnt + 1;
            if (!m_fev) begin
               m_fev = 1; m_faddr = p_addr; m_flanes = p_lanes;
            end
         end
      end
      // evaluate the beat on this edge
      p_vld = beat;
      p_unexp = beat && (sz == 0);
      p_addr = '0;
      p_lanes = '1;
      if (popped) begin
         p_addr = m_q[0];
         for (int i = 0; i < LANES; i++)
            p_lanes[i] = (tg_rd_data[i*32 +: 32] != (m_q[0] + 32'(i)));
         void'(m_q.pop_front());
      end
      if (rdc) begin
         if (sz < DEPTH || popped) m_q.push_back(tg_addr);
         else m_ovf = 1;
      end
      case (st)
         M_IDLE:  if (chk_en) m_st = M_RUN;
         M_RUN:   if (!chk_en) m_st = (sz > 0) ? M_DRAIN : M_IDLE;
         M_DRAIN: if (chk_en) m_st = M_RUN; else if (sz == 0) m_st = M_IDLE;
         default: m_st = M_IDLE;
      endcase
   endtask

   initial forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else        model_step();
   end

   // Cycle compare against the model, away from the active edge
   initial forever begin
      @(negedge clk);
      if (rst_n) begin
         check("chk_busy",        64'(chk_busy),        64'(m_st != M_IDLE));
         check("outstanding",     64'(outstanding),     64'(m_q.size()));
         check("err_flag",        64'(err_flag),        64'(m_err_flag));
         check("err_cnt",         64'(err_cnt),         64'(m_err_cnt));
         check("cmp_cnt",         64'(cmp_cnt),         64'(m_cmp_cnt));
         check("first_err_vld",   64'(first_err_vld),   64'(m_fev));
         check("first_err_addr",  64'(first_err_addr),  64'(m_faddr));
         check("first_err_lanes", 64'(first_err_lanes), 64'(m_flanes));
         check("fifo_ovf",        64'(fifo_ovf),        64'(m_ovf));
         check("unexp_data",      64'(unexp_data),      64'(m_unexp));
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [DW-1:0] good_data(input logic [31:0] a);
      logic [DW-1:0] d;
      d = '0;
      for (int i = 0; i < LANES; i++) d[i*32 +: 32] = a + 32'(i);
      return d;
   endfunction

   function automatic logic [DW-1:0] rand_data();
      logic [DW-1:0] d;
      d = '0;
      for (int i = 0; i < LANES; i++) d[i*32 +: 32] = $urandom;
      return d;
   endfunction

   task automatic issue_read(input logic [31:0] a);
      tg_en = 1'b1; tg_rdy = 1'b1; tg_cmd = 3'b001; tg_addr = a;
      step();
      tg_en = 1'b0; tg_rdy = 1'b0; tg_cmd = '0;
   endtask

   task automatic send_beat(input logic [DW-1:0] d);
      tg_rd_data_valid = 1'b1; tg_rd_data = d;
      step();
      tg_rd_data_valid = 1'b0;
   endtask

   task automatic pulse_clr();
      clr_err = 1'b1;
      step();
      clr_err = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, " chk_busy"},        64'(chk_busy),        64'd0);
      check({tag, " outstanding"},     64'(outstanding),     64'd0);
      check({tag, " err_flag"},        64'(err_flag),        64'd0);
      check({tag, " err_cnt"},         64'(err_cnt),         64'd0);
      check({tag, " cmp_cnt"},         64'(cmp_cnt),         64'd0);
      check({tag, " first_err_vld"},   64'(first_err_vld),   64'd0);
      check({tag, " first_err_addr"},  64'(first_err_addr),  64'd0);
      check({tag, " first_err_lanes"}, 64'(first_err_lanes), 64'd0);
      check({tag, " fifo_ovf"},        64'(fifo_ovf),        64'd0);
      check({tag, " unexp_data"},      64'(unexp_data),      64'd0);
   endtask

   // ---------------- test sequence ----------------
   initial begin
      logic [DW-1:0] d;
      int            guard;
      int            pop_pct;
      int            k;

      repeat (3) step();
      check_all_zero("reset");
      rst_n = 1'b1;
      step();

      // Four good reads 0x100..0x103
      chk_en = 1'b1;
      step();
      for (int i = 0; i < 4; i++) issue_read(32'h100 + 32'(i));
      check("wr4 outstanding", 64'(outstanding), 64'd4);
      for (int i = 0; i < 4; i++) send_beat(good_data(32'h100 + 32'(i)));
      repeat (3) step();
      check("wr4 cmp_cnt",     64'(cmp_cnt),     64'd4);
      check("wr4 err_cnt",     64'(err_cnt),     64'd0);
      check("wr4 err_flag",    64'(err_flag),    64'd0);
      check("wr4 outstanding", 64'(outstanding), 64'd0);

      // Lane 3 corrupted on 0x200: status two cycles after the beat
      issue_read(32'h200);
      d = good_data(32'h200);
      d[3*32 +: 32] = d[3*32 +: 32] ^ 32'h0000_0001;
      send_beat(d);
      check("lane3 err_flag cycle1", 64'(err_flag), 64'd0);
      step();
      check("lane3 err_flag",        64'(err_flag),        64'd1);
      check("lane3 err_cnt",         64'(err_cnt),         64'd1);
      check("lane3 first_err_addr",  64'(first_err_addr),  64'h200);
      check("lane3 first_err_lanes", 64'(first_err_lanes), 64'h0008);

      // 17 reads into a 16-deep FIFO, then 16 good beats
      pulse_clr();
      for (int i = 0; i < 17; i++) issue_read(32'h300 + 32'(i));
      check("ovf fifo_ovf",    64'(fifo_ovf),    64'd1);
      check("ovf outstanding", 64'(outstanding), 64'd16);
      for (int i = 0; i < 16; i++) send_beat(good_data(32'h300 + 32'(i)));
      repeat (3) step();
      check("ovf err_cnt", 64'(err_cnt), 64'd0);
      check("ovf cmp_cnt", 64'(cmp_cnt), 64'd16);

      // Beat with an empty FIFO
      pulse_clr();
      send_beat(rand_data());
      repeat (2) step();
      check("unexp unexp_data",      64'(unexp_data),      64'd1);
      check("unexp err_cnt",         64'(err_cnt),         64'd1);
      check("unexp first_err_lanes", 64'(first_err_lanes), 64'hFFFF);
      check("unexp first_err_addr",  64'(first_err_addr),  64'd0);

      // Drain with three reads outstanding
      pulse_clr();
      for (int i = 0; i < 3; i++) issue_read(32'h400 + 32'(i));
      chk_en = 1'b0;
      step();
      check("drain chk_busy", 64'(chk_busy), 64'd1);
      issue_read(32'h500);
      issue_read(32'h501);
      check("drain no push", 64'(outstanding), 64'd3);
      for (int i = 0; i < 3; i++) send_beat(good_data(32'h400 + 32'(i)));
      step();
      check("drain done chk_busy", 64'(chk_busy), 64'd0);
      // beat while IDLE is ignored
      send_beat(rand_data());
      repeat (2) step();
      check("idle beat unexp_data", 64'(unexp_data), 64'd0);
      check("drain cmp_cnt",        64'(cmp_cnt),    64'd3);
      check("drain err_cnt",        64'(err_cnt),    64'd0);

      // Randomized traffic
      chk_en = 1'b1;
      for (int c = 0; c < 3000; c++) begin
         pop_pct = ((c / 400) % 2 == 1) ? 5 : 55;
         if ($urandom_range(0, 199) == 0) chk_en = ~chk_en;
         clr_err = ($urandom_range(0, 99) == 0);
         tg_en   = ($urandom_range(0, 1) == 1);
         tg_rdy  = ($urandom_range(0, 3) != 0);
         tg_cmd  = ($urandom_range(0, 3) == 0) ? CW'($urandom) : 3'b001;
         tg_addr = $urandom;
         if (m_q.size() > 0) begin
            tg_rd_data_valid = ($urandom_range(0, 99) < pop_pct);
            d = good_data(m_q[0]);
            if ($urandom_range(0, 9) == 0) begin
               k = $urandom_range(0, LANES - 1);
               d[k*32 +: 32] = d[k*32 +: 32] ^ ($urandom | 32'h1);
            end
            tg_rd_data = d;
         end else begin
            tg_rd_data_valid = ($urandom_range(0, 19) == 0);
            tg_rd_data = rand_data();
         end
         step();
      end
      tg_en = 1'b0; tg_rdy = 1'b0; tg_cmd = '0; clr_err = 1'b0; tg_rd_data_valid = 1'b0;

      // Empty the FIFO in RUN
      chk_en = 1'b1;
      step();
      guard = 0;
      while (m_q.size() > 0 && guard < 40) begin
         send_beat(good_data(m_q[0]));
         guard++;
      end
      check("drain loop empty", 64'(outstanding), 64'd0);
      repeat (2) step();

      // Failure committing on the clear cycle
      pulse_clr();
      issue_read(32'h600);
      issue_read(32'h601);
      d = good_data(32'h600);
      d[1*32 +: 32] = ~d[1*32 +: 32];
      send_beat(d);
      d = good_data(32'h601);
      d[5*32 +: 32] = d[5*32 +: 32] + 32'd7;
      send_beat(d);
      check("pre-clr first_err_addr", 64'(first_err_addr), 64'h600);
      check("pre-clr err_cnt",        64'(err_cnt),        64'd1);
      pulse_clr();
      check("clr+fail err_cnt",         64'(err_cnt),         64'd1);
      check("clr+fail cmp_cnt",         64'(cmp_cnt),         64'd1);
      check("clr+fail first_err_vld",   64'(first_err_vld),   64'd1);
      check("clr+fail first_err_addr",  64'(first_err_addr),  64'h601);
      check("clr+fail first_err_lanes", 64'(first_err_lanes), 64'h0020);

      // Reset mid-stream with a failing beat in flight
      issue_read(32'h700);
      issue_read(32'h701);
      send_beat(rand_data());
      rst_n = 1'b0;
      #1;
      check_all_zero("async reset");
      repeat (2) step();
      check_all_zero("held reset");
      rst_n = 1'b1;
      step();
      send_beat(rand_data());
      repeat (2) step();
      check("post-reset unexp_data", 64'(unexp_data), 64'd1);
      check("post-reset err_cnt",    64'(err_cnt),    64'd1);
      repeat (2) step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
